ecc_err_logger: RTL

//  Downstream of the ECC read-path decoder. Captures each error report (single/double,

---
 rtl/ecc_err_logger.sv | 133 +++++++++++++
 1 files changed

// File: rtl/ecc_err_logger.sv
// ECC error-report logger: show-ahead FIFO of decoded error events plus
// saturating CE/UE/overflow counters and sticky interrupt flags.
module ecc_err_logger #(
    parameter int ADDR_W    = 32,
    parameter int DEPTH     = 8,
    parameter int CE_THRESH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       err_valid,
    input  logic                       single_err,
    input  logic                       double_err,
    input  logic                       err_corr,
    input  logic [7:0]                 err_pos,
    input  logic [ADDR_W-1:0]          err_addr,
    output logic                       log_valid,
    input  logic                       log_ready,
    output logic [ADDR_W+9:0]          log_data,
    output logic [$clog2(DEPTH):0]     log_count,
    output logic [15:0]                ce_cnt,
    output logic [15:0]                ue_cnt,
    output logic [15:0]                ovf_cnt,
    output logic                       irq_ce,
    output logic                       irq_ue,
    input  logic                       clr_stats,
    input  logic                       flush
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = ADDR_W + 10;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [15:0]      CE_TH    = 16'(CE_THRESH);

    logic [ENT_W-1:0] mem_q [DEPTH];
    logic [ENT_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [15:0]      ce_cnt_q, ce_cnt_d, ue_cnt_q, ue_cnt_d, ovf_cnt_q, ovf_cnt_d;
    logic             irq_ce_q, irq_ce_d, irq_ue_q, irq_ue_d;

    logic             ev, ce_ev, ue_ev, full, pop, push, drop;
    logic [ENT_W-1:0] entry;
    logic [15:0]      ce_next;

    // Handshake: an entry transfers on any cycle where log_valid & log_ready;
    // log_valid never depends on log_ready, and log_data is held until popped.
    always_comb begin
        ev    = err_valid & (single_err | double_err);
        ue_ev = ev & double_err;
        ce_ev = ev & ~double_err;
        entry = double_err ? {1'b1, 1'b0, 8'd0, err_addr}
                           : {1'b0, err_corr, err_pos, err_addr};
        full  = (count_q == FULL_CNT);
        pop   = (count_q != '0) & log_ready;
        // A full FIFO still accepts a push when the head leaves in the same cycle.
        push  = ev & ~flush & (~full | pop);
        drop  = ev & ~flush & full & ~pop;

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = entry;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end

        ce_next   = (ce_cnt_q == 16'hFFFF) ? ce_cnt_q : ce_cnt_q + 16'd1;
        ce_cnt_d  = ce_cnt_q;
        ue_cnt_d  = ue_cnt_q;
        ovf_cnt_d = ovf_cnt_q;
        irq_ce_d  = irq_ce_q;
        irq_ue_d  = irq_ue_q;
        if (clr_stats) begin
            ce_cnt_d  = '0;
            ue_cnt_d  = '0;
            ovf_cnt_d = '0;
            irq_ce_d  = 1'b0;
            irq_ue_d  = 1'b0;
        end else begin
            if (ce_ev) begin
                ce_cnt_d = ce_next;
                if (ce_next >= CE_TH) irq_ce_d = 1'b1;
            end
            if (ue_ev) begin
                if (ue_cnt_q != 16'hFFFF) ue_cnt_d = ue_cnt_q + 16'd1;
                irq_ue_d = 1'b1;
            end
            if (drop && ovf_cnt_q != 16'hFFFF) ovf_cnt_d = ovf_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ce_cnt_q  <= '0;
            ue_cnt_q  <= '0;
            ovf_cnt_q <= '0;
            irq_ce_q  <= 1'b0;
            irq_ue_q  <= 1'b0;
        end else begin
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ce_cnt_q  <= ce_cnt_d;
            ue_cnt_q  <= ue_cnt_d;
            ovf_cnt_q <= ovf_cnt_d;
            irq_ce_q  <= irq_ce_d;
            irq_ue_q  <= irq_ue_d;
        end
    end

    assign log_valid = (count_q != '0);
    assign log_data  = log_valid ? mem_q[rd_ptr_q] : '0;
    assign log_count = count_q;
    assign ce_cnt    = ce_cnt_q;
    assign ue_cnt    = ue_cnt_q;
    assign ovf_cnt   = ovf_cnt_q;
    assign irq_ce    = irq_ce_q;
    assign irq_ue    = irq_ue_q;
endmodule
